dt_sti_loader: RTL and testbench
================================

// Module: dt_sti_loader
// PURPOSE
//  Front-end stage of the distance-transform engine. Reads the packed binary
//  image from sti_ROM: 1024 words x 16 bit, 128x128 pixels, MSB = leftmost pixel.
//  Unpacks each word and writes one byte per pixel into res_RAM (8'h01 object,
//  8'h00 background). The forward and backward DT passes then operate in place.
//  Optionally forces the one-pixel image border to background. Counts object pixels.
// PARAMETERS
//  IMG_W        128  image width/height in pixels (power of 2; address = {row,col})
//  BORDER_CLEAR 1    1: row 0/127 and col 0/127 written as 8'h00 regardless of ROM
// PORTS
//  clk        in   1   system clock; all state changes on posedge
//  reset      in   1   asynchronous, active-low reset
//  start      in   1   level-sampled on posedge; begins a load when in IDLE
//  busy       out  1   high in RD and WR states
//  load_done  out  1   one-cycle pulse (DONE state) after the last pixel write
//  sti_rd     out  1   ROM read enable; ROM samples addr on negedge, data valid next posedge
//  sti_addr   out  10  ROM word index
//  sti_di     in   16  ROM data
//  res_wr     out  1   RAM write enable; RAM writes on posedge
//  res_addr   out  14  RAM pixel address = word_idx*16 + bit_cnt = {row[6:0],col[6:0]}
//  res_do     out  8   RAM write data
//  obj_count  out  15  number of 8'h01 bytes written in the current/last load
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; all outputs 0; word_idx=0, bit_cnt=0, shreg=0.
//  FSM: IDLE -start-> RD -> WR (16384 cycles) -> DONE -> IDLE.
//   IDLE: outputs idle; obj_count holds last result; start=1 -> RD, obj_count<=0.
//   RD:   sti_rd=1, sti_addr=0; shreg<=sti_di at end of cycle; -> WR, bit_cnt=0.
//   WR:   res_wr=1, res_addr={word_idx,bit_cnt}, pixel = shreg[15-bit_cnt].
//         Writes 8'h01 if pixel=1 and not (BORDER_CLEAR & border), else 8'h00.
//         border = row==0 | row==IMG_W-1 | col==0 | col==IMG_W-1.
//         bit_cnt==15 & word_idx<1023: sti_rd=1, sti_addr=word_idx+1; shreg<=sti_di,
//         word_idx++, bit_cnt wraps to 0 (no bubble; 16 writes per word).
//         bit_cnt==15 & word_idx==1023: sti_rd=0 -> DONE.
//         obj_count increments in the same cycle as each 8'h01 write.
//   DONE: load_done=1, busy=0, res_wr=0 -> IDLE; word_idx, bit_cnt cleared.
//  Latency: start sampled at edge E -> first res_wr in cycle E+2 -> last write cycle E+16385;
//   load_done high in cycle E+16386.
//  sti_rd is high only in RD and on WR bit_cnt==15 (1024 reads total); sti_addr holds otherwise.
//  start while busy or in DONE: ignored. start held high: a new load begins from IDLE.
//  Reset mid-load: immediate abort to IDLE; partial RAM contents are not undone.
//  No combinational path from start/sti_di to any output; all outputs decode registers.
//  obj_count saturates impossible: max 16384 fits 15 bits.
// TESTING
//  T1 ROM all 16'hFFFF, BORDER_CLEAR=1 -> 15876 interior bytes 01, border 00, obj_count=15876.
//  T2 same ROM, BORDER_CLEAR=0 -> all 16384 bytes 01, obj_count=16384.
//  T3 ROM 0 except word 8=16'h8001 -> RAM[128]=00 (border), RAM[143]=01, obj_count=1.
//  T4 Cycle check: start at edge E -> first res_wr cycle E+2; load_done one cycle at E+16386;
//     exactly 1024 sti_rd cycles.
//  T5 reset low at write 5000 -> all outputs 0 next sample; new start reloads fully, correct result.
//  T6 start pulses while busy -> no restart, single load_done.

Source files
------------

// File: rtl/dt_sti_loader_if.sv
// Bus bundle for the distance-transform image loader.
//   start/busy/load_done/obj_count : load control and status
//   sti_rd/sti_addr/sti_di         : packed-image ROM read port (16-bit words)
//   res_wr/res_addr/res_do         : one-byte-per-pixel result RAM write port
// Modport slave is the loader; master is whoever drives start and the ROM data.
interface dt_sti_loader_if #(
    parameter int unsigned IMG_W = 128
);
    localparam int unsigned PIX_AW  = 2 * $clog2(IMG_W);
    localparam int unsigned WORD_AW = PIX_AW - 4;

    logic               start;
    logic               busy;
    logic               load_done;
    logic               sti_rd;
    logic [WORD_AW-1:0] sti_addr;
    logic [15:0]        sti_di;
    logic               res_wr;
    logic [PIX_AW-1:0]  res_addr;
    logic [7:0]         res_do;
    logic [PIX_AW:0]    obj_count;

    modport slave (
        input  start, sti_di,
        output busy, load_done, sti_rd, sti_addr, res_wr, res_addr, res_do, obj_count
    );

    modport master (
        output start, sti_di,
        input  busy, load_done, sti_rd, sti_addr, res_wr, res_addr, res_do, obj_count
    );
endinterface

// File: rtl/dt_sti_loader.sv
// Front-end of the distance-transform engine: unpacks the 1-bit-per-pixel
// ROM image (MSB = leftmost pixel) into one byte per pixel in the result RAM,
// optionally forcing the image border to background, and counts object pixels.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : dt_sti_loader_if.slave (control/status, ROM read, RAM write)
// Outputs are decoded from registered state only; start and sti_di never reach
// an output combinationally.
module dt_sti_loader #(
    parameter int unsigned IMG_W        = 128,
    parameter bit          BORDER_CLEAR = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    dt_sti_loader_if.slave bus
);
    localparam int unsigned CW      = $clog2(IMG_W);
    localparam int unsigned PIX_AW  = 2 * CW;
    localparam int unsigned WORD_AW = PIX_AW - 4;
    localparam int unsigned CNT_W   = PIX_AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [WORD_AW-1:0] word_idx_q, word_idx_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [15:0]        shreg_q, shreg_d;
    logic [WORD_AW-1:0] sti_addr_q, sti_addr_d;
    logic [CNT_W-1:0]   obj_cnt_q, obj_cnt_d;

    logic          last_bit, last_word, pixel, border, obj_wr;
    logic [CW-1:0] row, col;

    // Pixel address {word_idx,bit_cnt} is also {row,col}
    assign {row, col} = {word_idx_q, bit_cnt_q};
    assign last_bit   = (bit_cnt_q == 4'd15);
    assign last_word  = (word_idx_q == {WORD_AW{1'b1}});
    assign pixel      = shreg_q[4'd15 - bit_cnt_q];
    assign border     = (row == '0) || (row == '1) || (col == '0) || (col == '1);
    assign obj_wr     = (state_q == S_WR) && pixel && !(BORDER_CLEAR && border);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RD;
            S_RD:    state_d = S_WR;
            S_WR:    if (last_bit && last_word) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        word_idx_d = word_idx_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        sti_addr_d = sti_addr_q;
        obj_cnt_d  = obj_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    word_idx_d = '0;
                    bit_cnt_d  = '0;
                    sti_addr_d = '0;
                    obj_cnt_d  = '0;
                end
            end
            S_RD: begin
                shreg_d   = bus.sti_di;
                bit_cnt_d = '0;
            end
            S_WR: begin
                if (obj_wr) obj_cnt_d = obj_cnt_q + CNT_W'(1);
                bit_cnt_d = bit_cnt_q + 4'd1;
                // Address must be stable for the whole bit-15 cycle, so set it one write early
                if (bit_cnt_q == 4'd14 && !last_word) sti_addr_d = word_idx_q + WORD_AW'(1);
                if (last_bit) begin
                    if (last_word) begin
                        word_idx_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        shreg_d    = bus.sti_di;
                        word_idx_d = word_idx_q + WORD_AW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            sti_addr_q <= '0;
            obj_cnt_q  <= '0;
        end else begin
            word_idx_q <= word_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            sti_addr_q <= sti_addr_d;
            obj_cnt_q  <= obj_cnt_d;
        end
    end

    // Output decode
    always_comb begin
        bus.busy      = 1'b0;
        bus.load_done = 1'b0;
        bus.sti_rd    = 1'b0;
        bus.res_wr    = 1'b0;
        bus.res_do    = 8'h00;
        bus.sti_addr  = sti_addr_q;
        bus.res_addr  = {word_idx_q, bit_cnt_q};
        bus.obj_count = obj_cnt_q;
        unique case (state_q)
            S_RD: begin
                bus.busy   = 1'b1;
                bus.sti_rd = 1'b1;
            end
            S_WR: begin
                bus.busy   = 1'b1;
                bus.res_wr = 1'b1;
                bus.sti_rd = last_bit && !last_word;
                bus.res_do = {7'b0, obj_wr};
            end
            S_DONE:  bus.load_done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dt_sti_loader.sv
// Self-checking bench for dt_sti_loader: two instances (border clear on/off)
// share a ROM model; RAM contents, object counts and cycle timing are compared
// against a pixel-level reference model of the image rules.
module tb_dt_sti_loader;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dt_sti_loader_if #(.IMG_W(128)) b1 ();
    dt_sti_loader_if #(.IMG_W(128)) b2 ();

    dt_sti_loader #(.IMG_W(128), .BORDER_CLEAR(1'b1)) dut_bc (
        .clk(clk), .reset(reset), .bus(b1.slave)
    );
    dt_sti_loader #(.IMG_W(128), .BORDER_CLEAR(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .bus(b2.slave)
    );

    logic [15:0] rom  [1024];
    logic [7:0]  ram1 [16384];
    logic [7:0]  ram2 [16384];

    int cyc = 0;
    int wr_tot = 0;
    int rd_tot = 0;
    int done_tot = 0;
    int done_cyc = 0;
    int first_wr_cyc = 0;
    logic wr_prev = 1'b0;
    int checks = 0;
    int errors = 0;

    // ROM: address sampled on negedge, data valid at the next posedge
    always @(negedge clk) begin
        if (b1.sti_rd) b1.sti_di <= rom[b1.sti_addr];
        if (b2.sti_rd) b2.sti_di <= rom[b2.sti_addr];
    end

    // RAM write ports and activity monitor; cyc is the index of the current edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (b1.res_wr) begin
            ram1[b1.res_addr] <= b1.res_do;
            wr_tot <= wr_tot + 1;
        end
        if (b1.res_wr && !wr_prev) first_wr_cyc <= cyc;
        wr_prev <= b1.res_wr;
        if (b2.res_wr) ram2[b2.res_addr] <= b2.res_do;
        if (b1.sti_rd) rd_tot <= rd_tot + 1;
        if (b1.load_done) begin
            done_tot <= done_tot + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: pixel p is row p/128, col p%128, bit (15 - p%16) of word p/16
    function automatic logic [7:0] exp_pix(input int p, input bit bc);
        int  row = p / 128;
        int  col = p % 128;
        logic [15:0] w = rom[p / 16];
        bit  px  = w[15 - (p % 16)];
        bit  brd = (row == 0) || (row == 127) || (col == 0) || (col == 127);
        return (px && !(bc && brd)) ? 8'h01 : 8'h00;
    endfunction

    function automatic int exp_obj(input bit bc);
        int n = 0;
        for (int p = 0; p < 16384; p++) if (exp_pix(p, bc) == 8'h01) n++;
        return n;
    endfunction

    function automatic int img_err(input bit bc);
        int n = 0;
        for (int p = 0; p < 16384; p++) begin
            if ((bc ? ram1[p] : ram2[p]) !== exp_pix(p, bc)) n++;
        end
        return n;
    endfunction

    // One complete load on both instances, with timing and content checks
    task automatic run_load(input string tag, input bit pulses);
        int e, k, wr0, rd0, dn0;
        wr0 = wr_tot; rd0 = rd_tot; dn0 = done_tot;
        @(negedge clk);
        b1.start = 1'b1; b2.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0; b2.start = 1'b0;
        e = cyc - 1;
        k = 0;
        while (done_tot == dn0 && k < 20000) begin
            @(negedge clk);
            k++;
            if (pulses && (k % 1000) == 500) begin
                b1.start = 1'b1; b2.start = 1'b1;
                @(negedge clk);
                b1.start = 1'b0; b2.start = 1'b0;
                k++;
            end
        end
        check({tag, "_timeout"}, 32'(k < 20000), 32'd1);
        repeat (20) @(negedge clk);
        check({tag, "_first_wr"}, 32'(first_wr_cyc), 32'(e + 2));
        check({tag, "_done_cyc"}, 32'(done_cyc), 32'(e + 16386));
        check({tag, "_rd_cnt"}, 32'(rd_tot - rd0), 32'd1024);
        check({tag, "_wr_cnt"}, 32'(wr_tot - wr0), 32'd16384);
        check({tag, "_done_cnt"}, 32'(done_tot - dn0), 32'd1);
        check({tag, "_idle_busy"}, 32'({b1.busy, b2.busy, b1.load_done}), 32'd0);
        check({tag, "_obj_bc"}, 32'(b1.obj_count), 32'(exp_obj(1'b1)));
        check({tag, "_obj_nb"}, 32'(b2.obj_count), 32'(exp_obj(1'b0)));
        check({tag, "_img_bc"}, 32'(img_err(1'b1)), 32'd0);
        check({tag, "_img_nb"}, 32'(img_err(1'b0)), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctl"}, 32'({b1.busy, b1.load_done, b1.sti_rd, b1.res_wr,
                                  b2.busy, b2.load_done, b2.sti_rd, b2.res_wr}), 32'd0);
        check({tag, "_addr"}, 32'({b1.sti_addr, b1.res_addr}), 32'd0);
        check({tag, "_do"}, 32'({b1.res_do, b2.res_do}), 32'd0);
        check({tag, "_obj"}, 32'({b1.obj_count, b2.obj_count}), 32'd0);
    endtask

    initial begin
        int k, wr0;
        reset = 1'b0;
        b1.start = 1'b0; b2.start = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // All-ones image: interior only with border clear, everything without
        for (int i = 0; i < 1024; i++) rom[i] = 16'hFFFF;
        run_load("ones", 1'b0);
        check("ones_obj_const_bc", 32'(b1.obj_count), 32'd15876);
        check("ones_obj_const_nb", 32'(b2.obj_count), 32'd16384);
        check("ones_ram0", 32'(ram1[0]), 32'h00);
        check("ones_ram129", 32'(ram1[129]), 32'h01);

        // Single word 8 = 16'h8001: col 0 (border) and col 15 of row 1
        for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
        rom[8] = 16'h8001;
        run_load("sparse", 1'b0);
        check("sparse_ram128_bc", 32'(ram1[128]), 32'h00);
        check("sparse_ram143_bc", 32'(ram1[143]), 32'h01);
        check("sparse_ram128_nb", 32'(ram2[128]), 32'h01);
        check("sparse_obj_const", 32'(b1.obj_count), 32'd1);

        // Random image, aborted by reset at write 5000
        for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
        wr0 = wr_tot;
        @(negedge clk);
        b1.start = 1'b1; b2.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0; b2.start = 1'b0;
        k = 0;
        while ((wr_tot - wr0) < 5000 && k < 10000) begin
            @(negedge clk);
            k++;
        end
        check("abort_timeout", 32'(k < 10000), 32'd1);
        reset = 1'b0;
        #1;
        check_zero_outputs("abort");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Fresh random image reloaded with start pulses during the load
        for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
        run_load("rand", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
